slice_judge: RTL and testbench
==============================

Name: slice_judge

Overview:
- Parametrised successor to the per-block slice checker.
- Judges one block per cycle against N hand sabers and the head, and emits these events, pipelined by 2 cycles:
  - slice event, with the winning hand index
  - obstacle-hit event
  - de-duplicated miss event
- Maintains a running score and combo multiplier.
- Sits between the block-state memory scan and the game-state/renderer update logic.

Parameters:
NUM_HANDS, 2, number of sabers (hand i carries color i%2: 0=red, 1=blue)
XW, 12, x coordinate width
YW, 12, y coordinate width
ZW, 14, z coordinate width
ID_W, 8, block ID width
MOVE_THRESH, 32, minimum |delta| of saber tip per frame to register a direction
HIT_HALF, 128, half-width of saber tip hit box (x and y)
HEAD_HALF, 96, half-width of head hit box (x and y)
Z_SLICE_MAX, 750, block z at or below which slicing/hits are possible
COMBO_MAX, 8, combo multiplier ceiling
SCORE_W, 20, score width

Ports:
clk_in  in  1  clock
rst_in  in  1  reset; asynchronous, active-low
curr_time  in  18  frame timestamp
blk_valid  in  1  block fields valid this cycle
blk_x  in  XW  block x
blk_y  in  YW  block y
blk_z  in  ZW  block z
blk_visible  in  1  block not yet destroyed
blk_color  in  1  required saber color
blk_obstacle  in  1  block is a wall (cannot be sliced)
blk_direction  in  3  required cut: 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT, 4 ANY
blk_id  in  ID_W  block ID
prev_tip_x  in  NUM_HANDS*XW  previous-frame tip x, hand i at [i*XW +: XW]
prev_tip_y  in  NUM_HANDS*YW  previous-frame tip y
tip_x  in  NUM_HANDS*XW  current tip x
tip_y  in  NUM_HANDS*YW  current tip y
head_x  in  XW  head x
head_y  in  YW  head y
sliced_valid  out  1  one-cycle slice pulse
sliced_hand  out  max(1,$clog2(NUM_HANDS))  winning hand index
sliced_x, sliced_y, sliced_z  out  XW/YW/ZW  block position at slice
sliced_color, sliced_dir, sliced_id  out  1/3/ID_W  block fields at slice
player_hit  out  1  one-cycle obstacle-hit pulse
block_missed  out  1  one-cycle miss pulse
missed_id  out  ID_W  ID of missed block
score  out  SCORE_W  accumulated score
combo  out  4  current multiplier

Behaviour:
- Reset (rst_in=0, asynchronous) clears:
  - both pipeline valids and all event outputs
  - last_slice_id, last_slice_time, last_miss_id and their valid flags
  - score to 0; combo is set to 1
- Stage 1 (registered), per hand i:
  - dx = tip_x - prev_tip_x, dy = tip_y - prev_tip_y, signed, XW+2 / YW+2 bits.
  - dir_i = RIGHT/LEFT (sign of dx) when |dx|>=MOVE_THRESH and |dx|>|dy|.
  - Otherwise dir_i = DOWN/UP (dy>=0 gives DOWN) when |dy|>=MOVE_THRESH and |dy|>|dx|.
  - Otherwise dir_i = ANY (also when |dx|==|dy|).
  - ovl_i: blk_x within [prev_tip_x-HIT_HALF, prev_tip_x+HIT_HALF], same test for y. Bounds saturate at 0 and 2^W-1; no wrap.
  - head_ovl: same test with head_x/head_y and HEAD_HALF.
  - Block fields are registered alongside.
- Stage 1 candidate for hand i: all of the following hold:
  - visible, !obstacle, z<=Z_SLICE_MAX, ovl_i
  - color(i)==blk_color
  - dir_i!=ANY and (blk_direction==ANY or dir_i==blk_direction)
- Stage 2 (registered outputs; total latency 2 cycles blk_valid -> events):
  - Slice: any candidate, and not (last_slice_valid and id==last_slice_id), and not (last_slice_valid and time==last_slice_time).
  - On slice: sliced_hand = lowest candidate index; latch id and time; score += combo, saturating at 2^SCORE_W-1; then combo = min(combo+1, COMBO_MAX).
  - player_hit: visible, obstacle, z<=Z_SLICE_MAX, head_ovl. Sets combo=1; score unchanged.
  - Miss: visible, !obstacle, z==0, no slice this cycle, and not (last_miss_valid and id==last_miss_id). Pulses block_missed, sets missed_id, latches last_miss_id, sets combo=1.
  - Slice and miss for the same block in the same cycle: slice wins.
  - Without a slice, sliced_* data fields hold their last value and sliced_valid=0.
- blk_valid=0 bubbles propagate; no events fire for bubbles.
- Reset asserted mid-pipeline discards in-flight blocks; no event fires on the first cycle after release.

Test Plan:
- Hand 0 tip (500,500)->(560,505), block (520,510,z=700) red RIGHT id=5 -> sliced_valid=1 two cycles later, sliced_hand=0, score=1, combo=2.
- Same block re-presented with the same id=5 next frame with identical motion -> no slice, score stays 1.
- Block z=751, otherwise valid; then a blue block cut by hand 0 (red) -> no slice in either case. The blue block cut by hand 1 -> sliced_hand=1.
- Delta (40,40) -> ANY, no slice even for a blk_direction=ANY block. Delta (0,-40) against an UP block -> slice.
- Unsliced block at z=0 id=9 presented 3 cycles -> exactly one block_missed, missed_id=9, combo=1.
- Obstacle at head position z=300 -> player_hit pulse, combo 5->1, score unchanged. Async reset mid-stream -> all outputs 0 immediately, combo=1.

Source files
------------

// File: rtl/slice_judge.sv
// Two-stage block judge: stage 1 registers per-hand cut direction, hit-box overlap and block
// fields; stage 2 resolves slice / obstacle-hit / miss events and keeps score and combo.
module slice_judge #(
    parameter int unsigned NUM_HANDS   = 2,
    parameter int unsigned XW          = 12,
    parameter int unsigned YW          = 12,
    parameter int unsigned ZW          = 14,
    parameter int unsigned ID_W        = 8,
    parameter int unsigned MOVE_THRESH = 32,
    parameter int unsigned HIT_HALF    = 128,
    parameter int unsigned HEAD_HALF   = 96,
    parameter int unsigned Z_SLICE_MAX = 750,
    parameter int unsigned COMBO_MAX   = 8,
    parameter int unsigned SCORE_W     = 20,
    localparam int unsigned HW         = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [17:0]             curr_time,
    input  logic                    blk_valid,
    input  logic [XW-1:0]           blk_x,
    input  logic [YW-1:0]           blk_y,
    input  logic [ZW-1:0]           blk_z,
    input  logic                    blk_visible,
    input  logic                    blk_color,
    input  logic                    blk_obstacle,
    input  logic [2:0]              blk_direction,
    input  logic [ID_W-1:0]         blk_id,
    input  logic [NUM_HANDS*XW-1:0] prev_tip_x,
    input  logic [NUM_HANDS*YW-1:0] prev_tip_y,
    input  logic [NUM_HANDS*XW-1:0] tip_x,
    input  logic [NUM_HANDS*YW-1:0] tip_y,
    input  logic [XW-1:0]           head_x,
    input  logic [YW-1:0]           head_y,
    output logic                    sliced_valid,
    output logic [HW-1:0]           sliced_hand,
    output logic [XW-1:0]           sliced_x,
    output logic [YW-1:0]           sliced_y,
    output logic [ZW-1:0]           sliced_z,
    output logic                    sliced_color,
    output logic [2:0]              sliced_dir,
    output logic [ID_W-1:0]         sliced_id,
    output logic                    player_hit,
    output logic                    block_missed,
    output logic [ID_W-1:0]         missed_id,
    output logic [SCORE_W-1:0]      score,
    output logic [3:0]              combo
);

    localparam logic [2:0] DIR_UP    = 3'd0;
    localparam logic [2:0] DIR_RIGHT = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_ANY   = 3'd4;

    localparam int unsigned DXW   = XW + 2;
    localparam int unsigned DYW   = YW + 2;
    localparam logic [31:0] X_MAX = 32'((64'd1 << XW) - 64'd1);
    localparam logic [31:0] Y_MAX = 32'((64'd1 << YW) - 64'd1);

    // Dominant-axis swipe direction; ties and slow motion yield ANY.
    function automatic logic [2:0] cut_dir(input logic [XW-1:0] px, input logic [XW-1:0] cx,
                                           input logic [YW-1:0] py, input logic [YW-1:0] cy);
        logic signed [DXW-1:0] dx;
        logic signed [DYW-1:0] dy;
        logic [31:0]           adx;
        logic [31:0]           ady;
        dx  = $signed({2'b00, cx}) - $signed({2'b00, px});
        dy  = $signed({2'b00, cy}) - $signed({2'b00, py});
        adx = dx[DXW-1] ? 32'(-dx) : 32'(dx);
        ady = dy[DYW-1] ? 32'(-dy) : 32'(dy);
        if (adx >= MOVE_THRESH && adx > ady) begin
            cut_dir = dx[DXW-1] ? DIR_LEFT : DIR_RIGHT;
        end else if (ady >= MOVE_THRESH && ady > adx) begin
            cut_dir = dy[DYW-1] ? DIR_UP : DIR_DOWN;
        end else begin
            cut_dir = DIR_ANY;
        end
    endfunction

    // Window [c-half, c+half] clamped to [0, vmax]; 33-bit sums avoid wrap.
    function automatic logic in_win(input logic [31:0] v, input logic [31:0] c,
                                    input logic [31:0] half, input logic [31:0] vmax);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = (c >= half) ? {1'b0, c - half} : 33'd0;
        hi = {1'b0, c} + {1'b0, half};
        if (hi > {1'b0, vmax}) begin
            hi = {1'b0, vmax};
        end
        in_win = ({1'b0, v} >= lo) && ({1'b0, v} <= hi);
    endfunction

    // Stage 1 combinational judgement
    logic [2:0]           hand_dir [NUM_HANDS];
    logic [NUM_HANDS-1:0] hand_ovl;
    logic [NUM_HANDS-1:0] cand_d;
    logic                 z_ok;
    logic                 sliceable;
    logic                 head_ovl;
    logic                 hit_d;
    logic                 miss_d;

    always_comb begin
        z_ok      = 32'(blk_z) <= Z_SLICE_MAX;
        sliceable = blk_visible && !blk_obstacle && z_ok;
        head_ovl  = in_win(32'(blk_x), 32'(head_x), HEAD_HALF, X_MAX) &&
                    in_win(32'(blk_y), 32'(head_y), HEAD_HALF, Y_MAX);
        hit_d     = blk_visible && blk_obstacle && z_ok && head_ovl;
        miss_d    = blk_visible && !blk_obstacle && (blk_z == '0);
        for (int i = 0; i < NUM_HANDS; i++) begin
            hand_dir[i] = cut_dir(prev_tip_x[i*XW +: XW], tip_x[i*XW +: XW],
                                  prev_tip_y[i*YW +: YW], tip_y[i*YW +: YW]);
            hand_ovl[i] = in_win(32'(blk_x), 32'(prev_tip_x[i*XW +: XW]), HIT_HALF, X_MAX) &&
                          in_win(32'(blk_y), 32'(prev_tip_y[i*YW +: YW]), HIT_HALF, Y_MAX);
            cand_d[i]   = sliceable && hand_ovl[i] && (blk_color == 1'(i % 2)) &&
                          (hand_dir[i] != DIR_ANY) &&
                          ((blk_direction == DIR_ANY) || (blk_direction == hand_dir[i]));
        end
    end

    logic                 s1_valid;
    logic [NUM_HANDS-1:0] s1_cand;
    logic                 s1_hit;
    logic                 s1_miss;
    logic [XW-1:0]        s1_x;
    logic [YW-1:0]        s1_y;
    logic [ZW-1:0]        s1_z;
    logic                 s1_color;
    logic [2:0]           s1_dir;
    logic [ID_W-1:0]      s1_id;
    logic [17:0]          s1_time;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_valid <= 1'b0;
            s1_cand  <= '0;
            s1_hit   <= 1'b0;
            s1_miss  <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_z     <= '0;
            s1_color <= 1'b0;
            s1_dir   <= '0;
            s1_id    <= '0;
            s1_time  <= '0;
        end else begin
            s1_valid <= blk_valid;
            s1_cand  <= cand_d;
            s1_hit   <= hit_d;
            s1_miss  <= miss_d;
            s1_x     <= blk_x;
            s1_y     <= blk_y;
            s1_z     <= blk_z;
            s1_color <= blk_color;
            s1_dir   <= blk_direction;
            s1_id    <= blk_id;
            s1_time  <= curr_time;
        end
    end

    // Stage 2 event resolution
    logic              last_slice_valid;
    logic [ID_W-1:0]   last_slice_id;
    logic [17:0]       last_slice_time;
    logic              last_miss_valid;
    logic [ID_W-1:0]   last_miss_id;
    logic              slice_go;
    logic              hit_go;
    logic              miss_go;
    logic [HW-1:0]     win_hand;
    logic [SCORE_W:0]  score_sum;
    logic [SCORE_W-1:0] score_next;
    logic [3:0]        combo_up;

    always_comb begin
        slice_go = s1_valid && (|s1_cand) &&
                   !(last_slice_valid && (s1_id == last_slice_id)) &&
                   !(last_slice_valid && (s1_time == last_slice_time));
        hit_go   = s1_valid && s1_hit;
        miss_go  = s1_valid && s1_miss && !slice_go &&
                   !(last_miss_valid && (s1_id == last_miss_id));
        win_hand = '0;
        for (int i = NUM_HANDS - 1; i >= 0; i--) begin
            if (s1_cand[i]) begin
                win_hand = HW'(i);
            end
        end
        score_sum  = {1'b0, score} + (SCORE_W + 1)'(combo);
        score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        combo_up   = (32'(combo) >= COMBO_MAX) ? 4'(COMBO_MAX) : combo + 4'd1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sliced_valid     <= 1'b0;
            sliced_hand      <= '0;
            sliced_x         <= '0;
            sliced_y         <= '0;
            sliced_z         <= '0;
            sliced_color     <= 1'b0;
            sliced_dir       <= '0;
            sliced_id        <= '0;
            player_hit       <= 1'b0;
            block_missed     <= 1'b0;
            missed_id        <= '0;
            score            <= '0;
            combo            <= 4'd1;
            last_slice_valid <= 1'b0;
            last_slice_id    <= '0;
            last_slice_time  <= '0;
            last_miss_valid  <= 1'b0;
            last_miss_id     <= '0;
        end else begin
            sliced_valid <= slice_go;
            player_hit   <= hit_go;
            block_missed <= miss_go;
            if (slice_go) begin
                sliced_hand      <= win_hand;
                sliced_x         <= s1_x;
                sliced_y         <= s1_y;
                sliced_z         <= s1_z;
                sliced_color     <= s1_color;
                sliced_dir       <= s1_dir;
                sliced_id        <= s1_id;
                last_slice_valid <= 1'b1;
                last_slice_id    <= s1_id;
                last_slice_time  <= s1_time;
                score            <= score_next;
                combo            <= combo_up;
            end else if (hit_go || miss_go) begin
                combo <= 4'd1;
            end
            if (miss_go) begin
                missed_id       <= s1_id;
                last_miss_valid <= 1'b1;
                last_miss_id    <= s1_id;
            end
        end
    end

endmodule

// File: tb/tb_slice_judge.sv
// Bench for slice_judge: directed scenarios plus randomized traffic against a frame-level model.
module tb_slice_judge;

    localparam int NH        = 2;
    localparam int XW        = 12;
    localparam int YW        = 12;
    localparam int ZW        = 14;
    localparam int IDW       = 8;
    localparam int SW        = 20;
    localparam int THRESH    = 32;
    localparam int HIT_HALF  = 128;
    localparam int HEAD_HALF = 96;
    localparam int ZMAX      = 750;
    localparam int CMAX      = 8;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [17:0]       curr_time;
    logic              blk_valid;
    logic [XW-1:0]     blk_x;
    logic [YW-1:0]     blk_y;
    logic [ZW-1:0]     blk_z;
    logic              blk_visible;
    logic              blk_color;
    logic              blk_obstacle;
    logic [2:0]        blk_direction;
    logic [IDW-1:0]    blk_id;
    logic [NH*XW-1:0]  prev_tip_x;
    logic [NH*YW-1:0]  prev_tip_y;
    logic [NH*XW-1:0]  tip_x;
    logic [NH*YW-1:0]  tip_y;
    logic [XW-1:0]     head_x;
    logic [YW-1:0]     head_y;
    logic              sliced_valid;
    logic [0:0]        sliced_hand;
    logic [XW-1:0]     sliced_x;
    logic [YW-1:0]     sliced_y;
    logic [ZW-1:0]     sliced_z;
    logic              sliced_color;
    logic [2:0]        sliced_dir;
    logic [IDW-1:0]    sliced_id;
    logic              player_hit;
    logic              block_missed;
    logic [IDW-1:0]    missed_id;
    logic [SW-1:0]     score;
    logic [3:0]        combo;

    int total;
    int bad;
    int t_now;

    slice_judge #(
        .NUM_HANDS(NH), .XW(XW), .YW(YW), .ZW(ZW), .ID_W(IDW), .MOVE_THRESH(THRESH),
        .HIT_HALF(HIT_HALF), .HEAD_HALF(HEAD_HALF), .Z_SLICE_MAX(ZMAX), .COMBO_MAX(CMAX),
        .SCORE_W(SW)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .curr_time(curr_time), .blk_valid(blk_valid),
        .blk_x(blk_x), .blk_y(blk_y), .blk_z(blk_z), .blk_visible(blk_visible),
        .blk_color(blk_color), .blk_obstacle(blk_obstacle), .blk_direction(blk_direction),
        .blk_id(blk_id), .prev_tip_x(prev_tip_x), .prev_tip_y(prev_tip_y), .tip_x(tip_x),
        .tip_y(tip_y), .head_x(head_x), .head_y(head_y), .sliced_valid(sliced_valid),
        .sliced_hand(sliced_hand), .sliced_x(sliced_x), .sliced_y(sliced_y),
        .sliced_z(sliced_z), .sliced_color(sliced_color), .sliced_dir(sliced_dir),
        .sliced_id(sliced_id), .player_hit(player_hit), .block_missed(block_missed),
        .missed_id(missed_id), .score(score), .combo(combo)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Reference model: expected output snapshot per cycle, two-cycle delay via queue.
    typedef struct {
        logic           sv;
        logic [0:0]     hand;
        logic [XW-1:0]  x;
        logic [YW-1:0]  y;
        logic [ZW-1:0]  z;
        logic           color;
        logic [2:0]     dir;
        logic [IDW-1:0] id;
        logic           hit;
        logic           missed;
        logic [IDW-1:0] mid;
        int             score;
        int             combo;
    } snap_t;

    snap_t          m_hold;
    snap_t          e_now;
    snap_t          exp_q[$];
    bit             m_lsv;
    logic [IDW-1:0] m_lsid;
    logic [17:0]    m_lst;
    bit             m_lmv;
    logic [IDW-1:0] m_lmid;

    function automatic bit near(int a, int c, int half);
        int d;
        d = a - c;
        if (d < 0) d = -d;
        return d <= half;
    endfunction

    function automatic bit can_cut(int i);
        int px, py, cx, cy, dx, dy, adx, ady, d;
        px = int'(prev_tip_x[i*XW +: XW]);
        py = int'(prev_tip_y[i*YW +: YW]);
        cx = int'(tip_x[i*XW +: XW]);
        cy = int'(tip_y[i*YW +: YW]);
        dx = cx - px;
        dy = cy - py;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        if (adx >= THRESH && adx > ady) d = (dx > 0) ? 1 : 3;
        else if (ady >= THRESH && ady > adx) d = (dy >= 0) ? 2 : 0;
        else d = 4;
        return blk_visible && !blk_obstacle && int'(blk_z) <= ZMAX &&
               near(int'(blk_x), px, HIT_HALF) && near(int'(blk_y), py, HIT_HALF) &&
               int'(blk_color) == (i % 2) && d != 4 &&
               (int'(blk_direction) == 4 || int'(blk_direction) == d);
    endfunction

    task automatic model_reset();
        m_hold = '{sv: 0, hand: 0, x: 0, y: 0, z: 0, color: 0, dir: 0, id: 0, hit: 0,
                   missed: 0, mid: 0, score: 0, combo: 1};
        m_lsv = 0; m_lsid = '0; m_lst = '0; m_lmv = 0; m_lmid = '0;
        exp_q.delete();
        exp_q.push_back(m_hold);
    endtask

    task automatic model_push();
        snap_t e;
        int    win;
        bit    slice, hit, miss;
        e = m_hold;
        e.sv = 0; e.hit = 0; e.missed = 0;
        if (blk_valid) begin
            win = -1;
            for (int i = 0; i < NH; i++) if (win < 0 && can_cut(i)) win = i;
            slice = (win >= 0) && !(m_lsv && blk_id == m_lsid) && !(m_lsv && curr_time == m_lst);
            hit = blk_visible && blk_obstacle && int'(blk_z) <= ZMAX &&
                  near(int'(blk_x), int'(head_x), HEAD_HALF) &&
                  near(int'(blk_y), int'(head_y), HEAD_HALF);
            miss = blk_visible && !blk_obstacle && blk_z == '0 && !slice &&
                   !(m_lmv && blk_id == m_lmid);
            if (slice) begin
                e.sv = 1; e.hand = 1'(win); e.x = blk_x; e.y = blk_y; e.z = blk_z;
                e.color = blk_color; e.dir = blk_direction; e.id = blk_id;
                m_lsv = 1; m_lsid = blk_id; m_lst = curr_time;
                e.score = (e.score + e.combo > (1 << SW) - 1) ? (1 << SW) - 1 : e.score + e.combo;
                e.combo = (e.combo + 1 > CMAX) ? CMAX : e.combo + 1;
            end
            if (hit) begin
                e.hit = 1; e.combo = 1;
            end
            if (miss) begin
                e.missed = 1; e.mid = blk_id; m_lmv = 1; m_lmid = blk_id; e.combo = 1;
            end
        end
        m_hold = e;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        curr_time = 18'(t_now);
        model_push();
        @(posedge clk_in);
        #1;
        if (exp_q.size() > 0) e_now = exp_q.pop_front();
    endtask

    task automatic set_hand(int i, int px, int py, int cx, int cy);
        prev_tip_x[i*XW +: XW] = XW'(px);
        prev_tip_y[i*YW +: YW] = YW'(py);
        tip_x[i*XW +: XW]      = XW'(cx);
        tip_y[i*YW +: YW]      = YW'(cy);
    endtask

    task automatic set_blk(bit v, int x, int y, int z, bit vis, bit col, bit obs, int d, int id);
        blk_valid = v; blk_x = XW'(x); blk_y = YW'(y); blk_z = ZW'(z);
        blk_visible = vis; blk_color = col; blk_obstacle = obs;
        blk_direction = 3'(d); blk_id = IDW'(id);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        #1 rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        total++; if (sliced_valid !== 1'b0) begin bad++; $display("FAIL reset_sv: got %0b want 0", sliced_valid); end
        total++; if (player_hit !== 1'b0) begin bad++; $display("FAIL reset_hit: got %0b want 0", player_hit); end
        total++; if (block_missed !== 1'b0) begin bad++; $display("FAIL reset_miss: got %0b want 0", block_missed); end
        total++; if (score !== '0) begin bad++; $display("FAIL reset_score: got %0d want 0", score); end
        total++; if (combo !== 4'd1) begin bad++; $display("FAIL reset_combo: got %0d want 1", combo); end
        total++; if (sliced_id !== '0 || missed_id !== '0) begin bad++; $display("FAIL reset_ids: got %0d/%0d want 0/0", sliced_id, missed_id); end
        #2 rst_in = 1'b1;
        model_reset();
    endtask

    task automatic test_basic_slice();
        t_now = 10;
        set_hand(0, 500, 500, 560, 505);
        set_hand(1, 2000, 2000, 2000, 2000);
        set_blk(1, 520, 510, 700, 1, 0, 0, 1, 5);
        tick();
        blk_valid = 0;
        total++; if (sliced_valid !== 1'b0) begin bad++; $display("FAIL basic_latency: got %0b want 0", sliced_valid); end
        tick();
        total++; if (sliced_valid !== 1'b1) begin bad++; $display("FAIL basic_sv: got %0b want 1", sliced_valid); end
        total++; if (sliced_hand !== 1'b0) begin bad++; $display("FAIL basic_hand: got %0d want 0", sliced_hand); end
        total++; if (sliced_id !== 8'd5 || sliced_x !== 12'd520 || sliced_z !== 14'd700) begin
            bad++; $display("FAIL basic_fields: got id=%0d x=%0d z=%0d want 5/520/700", sliced_id, sliced_x, sliced_z); end
        total++; if (score !== 20'd1 || combo !== 4'd2) begin bad++; $display("FAIL basic_score: got %0d/%0d want 1/2", score, combo); end
        tick();
        total++; if (sliced_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse: got %0b want 0", sliced_valid); end
        t_now = 11;
        set_blk(1, 520, 510, 700, 1, 0, 0, 1, 5);
        tick();
        blk_valid = 0;
        tick();
        total++; if (sliced_valid !== 1'b0 || score !== 20'd1) begin
            bad++; $display("FAIL dup_id: got sv=%0b score=%0d want 0/1", sliced_valid, score); end
    endtask

    task automatic test_filters();
        t_now = 12;
        set_blk(1, 520, 510, 751, 1, 0, 0, 1, 6);
        tick(); blk_valid = 0; tick();
        total++; if (sliced_valid !== 1'b0) begin bad++; $display("FAIL z751: got %0b want 0", sliced_valid); end
        t_now = 13;
        set_blk(1, 520, 510, 700, 1, 1, 0, 1, 7);
        tick(); blk_valid = 0; tick();
        total++; if (sliced_valid !== 1'b0) begin bad++; $display("FAIL wrong_color: got %0b want 0", sliced_valid); end
        t_now = 14;
        set_hand(0, 500, 500, 500, 500);
        set_hand(1, 500, 500, 560, 505);
        set_blk(1, 520, 510, 700, 1, 1, 0, 1, 7);
        tick(); blk_valid = 0; tick();
        total++; if (sliced_valid !== 1'b1 || sliced_hand !== 1'b1) begin
            bad++; $display("FAIL blue_hand1: got sv=%0b hand=%0d want 1/1", sliced_valid, sliced_hand); end
        total++; if (score !== 20'd3 || combo !== 4'd3) begin bad++; $display("FAIL blue_score: got %0d/%0d want 3/3", score, combo); end
    endtask

    task automatic test_direction();
        t_now = 15;
        set_hand(1, 2000, 2000, 2000, 2000);
        set_hand(0, 500, 500, 540, 540);
        set_blk(1, 520, 510, 700, 1, 0, 0, 4, 20);
        tick(); blk_valid = 0; tick();
        total++; if (sliced_valid !== 1'b0) begin bad++; $display("FAIL diag_any: got %0b want 0", sliced_valid); end
        t_now = 16;
        set_hand(0, 500, 540, 500, 500);
        set_blk(1, 500, 520, 700, 1, 0, 0, 0, 21);
        tick(); blk_valid = 0; tick();
        total++; if (sliced_valid !== 1'b1 || sliced_dir !== 3'd0 || sliced_id !== 8'd21) begin
            bad++; $display("FAIL up_cut: got sv=%0b dir=%0d id=%0d want 1/0/21", sliced_valid, sliced_dir, sliced_id); end
        total++; if (score !== 20'd6 || combo !== 4'd4) begin bad++; $display("FAIL up_score: got %0d/%0d want 6/4", score, combo); end
    endtask

    task automatic test_miss();
        int misses;
        t_now = 17;
        misses = 0;
        set_hand(0, 500, 500, 500, 500);
        set_blk(1, 520, 510, 0, 1, 0, 0, 1, 9);
        for (int k = 0; k < 5; k++) begin
            blk_valid = (k < 3);
            tick();
            if (block_missed === 1'b1) misses++;
        end
        total++; if (misses != 1) begin bad++; $display("FAIL miss_count: got %0d want 1", misses); end
        total++; if (missed_id !== 8'd9) begin bad++; $display("FAIL miss_id: got %0d want 9", missed_id); end
        total++; if (combo !== 4'd1 || score !== 20'd6) begin bad++; $display("FAIL miss_combo: got %0d/%0d want 1/6", combo, score); end
    endtask

    task automatic test_hit();
        for (int k = 0; k < 4; k++) begin
            t_now = 18 + k;
            set_hand(0, 500, 500, 560, 505);
            set_blk(1, 520, 510, 700, 1, 0, 0, 1, 40 + k);
            tick();
        end
        blk_valid = 0;
        tick();
        total++; if (combo !== 4'd5 || score !== 20'd16) begin bad++; $display("FAIL build_combo: got %0d/%0d want 5/16", combo, score); end
        t_now = 22;
        set_hand(0, 500, 500, 500, 500);
        head_x = 12'd1000; head_y = 12'd1000;
        set_blk(1, 1000, 1010, 300, 1, 0, 1, 4, 30);
        tick(); blk_valid = 0; tick();
        total++; if (player_hit !== 1'b1 || sliced_valid !== 1'b0) begin
            bad++; $display("FAIL hit_pulse: got hit=%0b sv=%0b want 1/0", player_hit, sliced_valid); end
        total++; if (combo !== 4'd1 || score !== 20'd16) begin bad++; $display("FAIL hit_combo: got %0d/%0d want 1/16", combo, score); end
        tick();
        total++; if (player_hit !== 1'b0) begin bad++; $display("FAIL hit_single: got %0b want 0", player_hit); end
    endtask

    function automatic int clampc(int v);
        return (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
    endfunction

    task automatic test_random();
        int px[NH];
        int py[NH];
        int h, bx, by, zsel, z, col;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(1) == 0) t_now++;
            for (int i = 0; i < NH; i++) begin
                px[i] = int'($urandom_range(4095));
                py[i] = int'($urandom_range(4095));
                set_hand(i, px[i], py[i], clampc(px[i] + int'($urandom_range(160)) - 80),
                         clampc(py[i] + int'($urandom_range(160)) - 80));
            end
            h  = int'($urandom_range(NH - 1));
            bx = clampc(px[h] + int'($urandom_range(280)) - 140);
            by = clampc(py[h] + int'($urandom_range(280)) - 140);
            zsel = int'($urandom_range(3));
            z = (zsel == 0) ? 0 : (zsel == 1) ? 750 : (zsel == 2) ? 751 : int'($urandom_range(1000));
            col = ($urandom_range(3) != 0) ? (h % 2) : int'($urandom_range(1));
            set_blk($urandom_range(5) != 0, bx, by, z, $urandom_range(7) != 0, 1'(col),
                    $urandom_range(5) == 0, int'($urandom_range(4)), int'($urandom_range(15)));
            head_x = XW'(clampc(bx + int'($urandom_range(200)) - 100));
            head_y = YW'(clampc(by + int'($urandom_range(200)) - 100));
            tick();
            total++; if ({sliced_valid, player_hit, block_missed} !== {e_now.sv, e_now.hit, e_now.missed}) begin
                bad++; $display("FAIL rand_events n=%0d: got %b want %b", n,
                    {sliced_valid, player_hit, block_missed}, {e_now.sv, e_now.hit, e_now.missed}); end
            total++; if ({sliced_hand, sliced_x, sliced_y, sliced_z, sliced_color, sliced_dir, sliced_id} !==
                         {e_now.hand, e_now.x, e_now.y, e_now.z, e_now.color, e_now.dir, e_now.id}) begin
                bad++; $display("FAIL rand_slice_data n=%0d: got hand=%0d id=%0d x=%0d want hand=%0d id=%0d x=%0d",
                    n, sliced_hand, sliced_id, sliced_x, e_now.hand, e_now.id, e_now.x); end
            total++; if (missed_id !== e_now.mid) begin
                bad++; $display("FAIL rand_missed_id n=%0d: got %0d want %0d", n, missed_id, e_now.mid); end
            total++; if (int'(score) != e_now.score || int'(combo) != e_now.combo) begin
                bad++; $display("FAIL rand_score n=%0d: got %0d/%0d want %0d/%0d", n, score, combo,
                    e_now.score, e_now.combo); end
        end
        blk_valid = 0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        t_now++;
        set_hand(0, 500, 500, 560, 505);
        set_hand(1, 2000, 2000, 2000, 2000);
        set_blk(1, 520, 510, 700, 1, 0, 0, 1, 200);
        tick();
        t_now++;
        set_blk(1, 520, 510, 700, 1, 0, 0, 1, 201);
        tick();
        total++; if (sliced_valid !== 1'b1 || sliced_id !== 8'd200) begin
            bad++; $display("FAIL async_pre: got sv=%0b id=%0d want 1/200", sliced_valid, sliced_id); end
        #2 rst_in = 1'b0;
        #1;
        total++; if (sliced_valid !== 1'b0 || score !== '0 || combo !== 4'd1) begin
            bad++; $display("FAIL async_now: got sv=%0b score=%0d combo=%0d want 0/0/1", sliced_valid, score, combo); end
        total++; if (sliced_x !== '0 || sliced_id !== '0) begin
            bad++; $display("FAIL async_fields: got x=%0d id=%0d want 0/0", sliced_x, sliced_id); end
        #2 rst_in = 1'b1;
        model_reset();
        blk_valid = 0;
        tick();
        total++; if (sliced_valid !== 1'b0) begin bad++; $display("FAIL post_rel1: got %0b want 0", sliced_valid); end
        tick();
        total++; if (sliced_valid !== 1'b0 || score !== '0) begin
            bad++; $display("FAIL inflight_drop: got sv=%0b score=%0d want 0/0", sliced_valid, score); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        t_now = 0;
        curr_time = '0;
        set_blk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_hand(0, 2000, 2000, 2000, 2000);
        set_hand(1, 2000, 2000, 2000, 2000);
        head_x = 12'd3000;
        head_y = 12'd3000;
        model_reset();
        test_reset();
        test_basic_slice();
        test_filters();
        test_direction();
        test_miss();
        test_hit();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
